// File: rtl/seq_control.sv
// Multi-cycle instruction sequencer: FETCH / DECODE / EXEC|MEM with PC-select and datapath strobes.
// Define SEQ_MEM_WAIT_EN to honour mem_ready with a bounded wait counter and sticky bus_err.
module seq_control #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  input  logic        flag_z,
  input  logic        flag_n,
  output logic [1:0]  ps,
  output logic [15:0] ir,
  output logic        ir_ld,
  output logic        mem_rd,
  output logic        mw,
  output logic        rf_we,
  output logic        md_sel,
  output logic        halted,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] C_ALU = 3'b000;
  localparam logic [2:0] C_LD  = 3'b001;
  localparam logic [2:0] C_ST  = 3'b010;
  localparam logic [2:0] C_LDI = 3'b011;
  localparam logic [2:0] C_BRZ = 3'b100;
  localparam logic [2:0] C_BRN = 3'b101;
  localparam logic [2:0] C_JMP = 3'b110;
  localparam logic [2:0] C_HLT = 3'b111;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JR   = 2'b11;

  logic [2:0] state_q, state_d;
  logic [2:0] cls;
  logic       ready;
  logic       timeout;

  assign state = state_q;
  assign cls   = ir[15:13];

`ifdef SEQ_MEM_WAIT_EN
  logic [7:0] wait_cnt;
  logic       waiting;

  assign ready   = mem_ready;
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  // A ready in the last allowed cycle completes the transfer rather than timing out.
  assign timeout = waiting && !mem_ready && (wait_cnt == 8'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      if (waiting && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
      else                       wait_cnt <= 8'd0;
      if (timeout)                          bus_err <= 1'b1;
      else if ((state_q == S_HALT) && run)  bus_err <= 1'b0;
    end
  end
`else
  logic unused_mem_ready;

  assign unused_mem_ready = mem_ready;
  assign ready            = 1'b1;
  assign timeout          = 1'b0;
  assign bus_err          = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir      <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (ir_ld) ir <= instr_in;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (ready) state_d = S_DECODE;
                else if (timeout) state_d = S_HALT;
      S_DECODE: begin
        case (cls)
          C_LD, C_ST: state_d = S_MEM;
          C_HLT:      state_d = S_HALT;
          default:    state_d = S_EXEC;
        endcase
      end
      S_EXEC:   state_d = S_FETCH;
      S_MEM:    if (ready) state_d = S_FETCH;
                else if (timeout) state_d = S_HALT;
      S_HALT:   if (run) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ps     = PS_HOLD;
    ir_ld  = 1'b0;
    mem_rd = 1'b0;
    mw     = 1'b0;
    rf_we  = 1'b0;
    md_sel = 1'b0;
    halted = (state_q == S_HALT);
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = ready;
      end
      S_EXEC: begin
        case (cls)
          C_ALU, C_LDI: begin
            rf_we = 1'b1;
            ps    = PS_INC;
          end
          C_BRZ:   ps = flag_z ? PS_BR : PS_INC;
          C_BRN:   ps = flag_n ? PS_BR : PS_INC;
          C_JMP:   ps = PS_JR;
          default: ps = PS_INC;
        endcase
      end
      S_MEM: begin
        if (cls == C_LD) begin
          mem_rd = 1'b1;
          if (ready) begin
            rf_we  = 1'b1;
            md_sel = 1'b1;
            ps     = PS_INC;
          end
        end else begin
          mw = 1'b1;
          if (ready) ps = PS_INC;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control.sv
// Scoreboard bench for seq_control: completion and halt events are checked against queued expectations.
// Covers both builds; the wait-counter scenarios run only when SEQ_MEM_WAIT_EN is defined.
module tb_seq_control;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  typedef struct packed {
    logic [1:0]  ps;
    logic        rf_we;
    logic        md_sel;
    logic        mem_rd;
    logic        mw;
    logic        halted;
    logic        bus_err;
    logic [15:0] ir;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr_in;
  logic        mem_ready;
  logic        flag_z;
  logic        flag_n;
  logic [1:0]  ps;
  logic [15:0] ir;
  logic        ir_ld, mem_rd, mw, rf_we, md_sel, halted, bus_err;
  logic [2:0]  state;

  int   n_cmp = 0;
  int   n_bad = 0;
  pkt_t exp_q[$];
  logic prev_halted = 1'b0;

  seq_control #(.WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_in(instr_in),
    .mem_ready(mem_ready), .flag_z(flag_z), .flag_n(flag_n),
    .ps(ps), .ir(ir), .ir_ld(ir_ld), .mem_rd(mem_rd), .mw(mw),
    .rf_we(rf_we), .md_sel(md_sel), .halted(halted), .bus_err(bus_err),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input logic [1:0] p, input logic we, input logic md,
                              input logic rd, input logic w, input logic h,
                              input logic be, input logic [15:0] i);
    pkt_t r;
    r.ps = p; r.rf_we = we; r.md_sel = md; r.mem_rd = rd;
    r.mw = w; r.halted = h; r.bus_err = be; r.ir = i;
    return r;
  endfunction

  // Monitor: an event is any cycle with ps != 0, or the first cycle of HALT.
  always @(negedge clk) begin
    pkt_t act, exp;
    if (!reset) begin
      prev_halted = 1'b0;
    end else begin
      if ((ps != 2'b00) || (halted && !prev_halted)) begin
        act = mk(ps, rf_we, md_sel, mem_rd, mw, halted, bus_err, ir);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got event %h, expected none (t=%0t)", act, $time);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_bad++;
            $display("FAIL sb_pkt: got ps=%b we=%b md=%b rd=%b mw=%b h=%b err=%b ir=%h, expected ps=%b we=%b md=%b rd=%b mw=%b h=%b err=%b ir=%h (t=%0t)",
                     act.ps, act.rf_we, act.md_sel, act.mem_rd, act.mw, act.halted, act.bus_err, act.ir,
                     exp.ps, exp.rf_we, exp.md_sel, exp.mem_rd, exp.mw, exp.halted, exp.bus_err, exp.ir, $time);
          end
        end
      end
      prev_halted = halted;
    end
  end

  // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r, input logic [15:0] i, input logic rdy,
                     input logic z, input logic n);
    @(posedge clk);
    #2;
    run = r; instr_in = i; mem_ready = rdy; flag_z = z; flag_n = n;
    @(negedge clk);
  endtask

  // Register/branch instruction; flags are inverted outside EXEC so only EXEC-cycle sampling passes.
  task automatic do_exec(input logic [15:0] i, input logic rdy, input logic z, input logic n,
                         input logic [1:0] eps, input logic ewe);
    exp_q.push_back(mk(eps, ewe, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i));
    cyc(1'b0, i, rdy, ~z, ~n);
    check("fetch_state", 32'(state), 32'(S_FETCH));
    check("fetch_ir_ld", 32'(ir_ld), 32'd1);
    check("fetch_bus_err", 32'(bus_err), 32'd0);
    cyc(1'b1, i, rdy, ~z, ~n);
    check("decode_state", 32'(state), 32'(S_DECODE));
    check("decode_ir", 32'(ir), 32'(i));
    cyc(1'b0, i, rdy, z, n);
    check("exec_state", 32'(state), 32'(S_EXEC));
  endtask

  task automatic do_mem(input logic [15:0] i, input int waits);
    logic is_ld;
    int   held;
    is_ld = (i[15:13] == 3'b001);
    held  = 0;
    exp_q.push_back(mk(2'b01, is_ld, is_ld, is_ld, ~is_ld, 1'b0, 1'b0, i));
    cyc(1'b0, i, 1'b1, 1'b0, 1'b0);
    check("mfetch_ir_ld", 32'(ir_ld), 32'd1);
    cyc(1'b0, i, 1'b1, 1'b0, 1'b0);
    check("mdecode_state", 32'(state), 32'(S_DECODE));
    for (int k = 0; k <= waits; k++) begin
      cyc(1'b0, i, (k == waits), 1'b0, 1'b0);
      if ((state == S_MEM) && (is_ld ? (mem_rd && !mw) : (mw && !mem_rd))) held++;
    end
    check("mem_strobe_cycles", 32'(held), 32'(waits + 1));
  endtask

  task automatic do_hlt();
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hE000));
    cyc(1'b0, 16'hE000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'hE000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'hE000, 1'b1, 1'b0, 1'b0);
    check("hlt_state", 32'(state), 32'(S_HALT));
    check("hlt_outs", 32'({halted, ps, rf_we, mem_rd, mw, ir_ld}), 32'b1_00_0000);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("hlt_stays", 32'(state), 32'(S_HALT));
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; instr_in = 16'h0000; mem_ready = 1'b0;
    flag_z = 1'b0; flag_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_outs", 32'({ps, ir_ld, mem_rd, mw, rf_we, md_sel, halted, bus_err}), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("idle_no_run", 32'(state), 32'(S_IDLE));

    // Run pulse then ALU op: ir_ld in cycle 1, ps=01 with rf_we in cycle 3.
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("idle_strobes", 32'({ps, ir_ld, mem_rd, mw, rf_we}), 32'd0);
    do_exec(16'h0000, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
    do_exec(16'h8005, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    do_exec(16'h8005, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    do_exec(16'hA003, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    do_exec(16'hA003, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    do_exec(16'hC000, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
    do_exec(16'h6012, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);

`ifdef SEQ_MEM_WAIT_EN
    // Ready on the last allowed wait cycle completes without error.
    do_mem(16'h2000, 3);
    do_mem(16'h4000, 1);
    // No ready in FETCH: four cycles of waiting then HALT with bus_err.
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4000));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
      check("berr_fetch", 32'({state, mem_rd, ir_ld}), 32'({S_FETCH, 1'b1, 1'b0}));
    end
    cyc(1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    check("berr_halt", 32'({state, halted, bus_err}), 32'({S_HALT, 1'b1, 1'b1}));
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("berr_sticky", 32'(bus_err), 32'd1);
    do_exec(16'h0000, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
`else
    do_mem(16'h2000, 0);
    do_mem(16'h4000, 0);
    // mem_ready is ignored in this build.
    do_exec(16'h0000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
`endif

    do_hlt();
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_exec(16'h6012, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);

    // Asynchronous reset in the middle of a load.
    cyc(1'b0, 16'h2000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h2000, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 mem_ready = 1'b0;
    #1 check("mid_ld_mem_rd", 32'({state, mem_rd}), 32'({S_MEM, 1'b1}));
    #1 reset = 1'b0;
    #1 check("async_rst_outs",
             32'({state, ps, ir_ld, mem_rd, mw, rf_we, md_sel, halted, bus_err}), 32'd0);
    check("async_rst_ir", 32'(ir), 32'd0);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(state), 32'(S_IDLE));
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("post_rst_no_run", 32'({state, rf_we, ps}), 32'd0);
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_exec(16'h6012, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
    do_hlt();
    repeat (2) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
